// File: rtl/store_buffer_if.sv
// Bundle of the core-side and memory-side signals of the store buffer.
//
// Core side:
//   memwrite, memread, dataadr, writedata  -> buffer
//   stall, fwd_hit, fwd_data               <- buffer
// Memory side:
//   m_ready                                -> buffer
//   m_valid, m_addr, m_data                <- buffer
// Status:
//   count, empty                           <- buffer
//
// slave  : the buffer's view
// master : the view of the core/memory driving the buffer
interface store_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          memwrite;
  logic          memread;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          stall;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          m_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [CW-1:0] count;
  logic          empty;

  modport slave (
    input  memwrite, memread, dataadr, writedata, m_ready,
    output stall, fwd_hit, fwd_data, m_valid, m_addr, m_data, count, empty
  );

  modport master (
    output memwrite, memread, dataadr, writedata, m_ready,
    input  stall, fwd_hit, fwd_data, m_valid, m_addr, m_data, count, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and data memory.
//
// Core stores are accepted in one cycle into a DEPTH-entry FIFO and drained
// to memory over a valid/ready handshake (m_valid/m_ready, head entry on
// m_addr/m_data). Loads (memread) are looked up against the queued stores and
// the youngest word-address match is forwarded on fwd_hit/fwd_data.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; discards all queued stores
//   bus    store_buffer_if.slave (core, memory and status signals)
//
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);

  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          is_empty;
  logic          enq;
  logic          deq;

  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] fwd_idx;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a value unassigned (no latch).
  always_comb begin
    full     = (count_q == FULL);
    is_empty = (count_q == '0);
    // A full buffer refuses the store even if the head leaves this cycle;
    // this keeps stall a function of registered state only.
    enq      = bus.memwrite & ~full;
    deq      = ~is_empty & bus.m_ready;

    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (enq) tail_d = tail_q + 1'b1;
    if (deq) head_d = head_q + 1'b1;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the entry array has no reset; its contents only matter once count
  // marks them occupied, and a resettable array costs a mux per bit.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= bus.dataadr;
      data_q[tail_q] <= bus.writedata;
    end
  end

  // Forwarding walks the occupied entries oldest to youngest; a later match
  // overrides an earlier one, so the youngest matching store wins. Byte
  // offset bits are ignored because all accesses are whole words.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (bus.memread && (CW'(i) < count_q) &&
          (addr_q[fwd_idx][AW-1:2] == bus.dataadr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign bus.stall    = bus.memwrite & full;
  assign bus.fwd_hit  = fwd_hit;
  assign bus.fwd_data = fwd_data;
  assign bus.m_valid  = ~is_empty;
  assign bus.m_addr   = is_empty ? '0 : addr_q[head_q];
  assign bus.m_data   = is_empty ? '0 : data_q[head_q];
  assign bus.count    = count_q;
  assign bus.empty    = is_empty;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based reference model is
// compared against every DUT output each falling edge, plus directed
// literal checks for the documented scenarios.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  store_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      bit do_enq;
      bit do_deq;
      do_enq = bus.memwrite && (q.size() < DEPTH);
      do_deq = (q.size() > 0) && bus.m_ready;
      if (do_deq) void'(q.pop_front());
      if (do_enq) q.push_back('{bus.dataadr, bus.writedata});
    end
  end

  // Every output checked against the model mid-cycle.
  always @(negedge clk) begin
    logic          e_hit;
    logic [DW-1:0] e_fdata;
    e_hit   = 1'b0;
    e_fdata = '0;
    if (bus.memread) begin
      for (int j = q.size() - 1; j >= 0; j--) begin
        if (q[j].a[AW-1:2] == bus.dataadr[AW-1:2]) begin
          e_hit   = 1'b1;
          e_fdata = q[j].d;
          break;
        end
      end
    end
    check("mdl_count",   64'(bus.count), 64'(q.size()));
    check("mdl_empty",   64'(bus.empty), 64'(q.size() == 0));
    check("mdl_stall",   64'(bus.stall), 64'(bus.memwrite && q.size() == DEPTH));
    check("mdl_m_valid", 64'(bus.m_valid), 64'(q.size() != 0));
    check("mdl_m_addr",  64'(bus.m_addr), (q.size() != 0) ? 64'(q[0].a) : 64'd0);
    check("mdl_m_data",  64'(bus.m_data), (q.size() != 0) ? 64'(q[0].d) : 64'd0);
    check("mdl_fwd_hit", 64'(bus.fwd_hit), 64'(e_hit));
    check("mdl_fwd_data", 64'(bus.fwd_data), 64'(e_fdata));
  end

  // Advance one rising edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_a [4] = '{4, 8, 12, 16};

  initial begin
    bus.memwrite  = 1'b0;
    bus.memread   = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    bus.m_ready   = 1'b0;

    // Reset state
    #1;
    check("rst_count",   64'(bus.count), 64'd0);
    check("rst_empty",   64'(bus.empty), 64'd1);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_stall",   64'(bus.stall), 64'd0);

    // Release at 22 ns with a store presented, memory ready
    #21;
    reset         = 1'b0;
    bus.memwrite  = 1'b1;
    bus.dataadr   = 32'd84;
    bus.writedata = 32'd7;
    bus.m_ready   = 1'b1;
    cyc();
    bus.memwrite = 1'b0;
    check("first_m_valid", 64'(bus.m_valid), 64'd1);
    check("first_m_addr",  64'(bus.m_addr), 64'd84);
    check("first_m_data",  64'(bus.m_data), 64'd7);
    cyc();
    check("first_drained", 64'(bus.count), 64'd0);

    // Fill and stall
    bus.m_ready  = 1'b0;
    bus.memwrite = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.dataadr   = 32'(4 * k);
      bus.writedata = 32'(100 + 4 * k);
      cyc();
    end
    check("fill_count", 64'(bus.count), 64'd4);
    bus.dataadr   = 32'd16;
    bus.writedata = 32'd116;
    #1;
    check("fill_stall", 64'(bus.stall), 64'd1);
    cyc();
    check("fill_count_held", 64'(bus.count), 64'd4);
    bus.m_ready = 1'b1;
    #1;
    check("stall_during_deq", 64'(bus.stall), 64'd1);
    check("drain_0", 64'(bus.m_addr), 64'd0);
    cyc();
    check("after_deq_count", 64'(bus.count), 64'd3);
    bus.m_ready = 1'b0;
    #1;
    check("retry_no_stall", 64'(bus.stall), 64'd0);
    cyc();
    check("retry_count", 64'(bus.count), 64'd4);
    bus.memwrite = 1'b0;
    bus.m_ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_order", 64'(bus.m_addr), 64'(exp_a[k]));
      cyc();
    end
    check("drain_empty", 64'(bus.empty), 64'd1);

    // Forwarding youngest
    bus.m_ready   = 1'b0;
    bus.memwrite  = 1'b1;
    bus.dataadr   = 32'd80;
    bus.writedata = 32'd1;
    cyc();
    bus.writedata = 32'd2;
    cyc();
    bus.memwrite = 1'b0;
    bus.memread  = 1'b1;
    #1;
    check("fwd80_hit",  64'(bus.fwd_hit), 64'd1);
    check("fwd80_data", 64'(bus.fwd_data), 64'd2);
    bus.dataadr = 32'd83;
    #1;
    check("fwd83_hit",  64'(bus.fwd_hit), 64'd1);
    check("fwd83_data", 64'(bus.fwd_data), 64'd2);
    bus.dataadr = 32'd84;
    #1;
    check("fwd84_hit",  64'(bus.fwd_hit), 64'd0);
    check("fwd84_data", 64'(bus.fwd_data), 64'd0);
    cyc();
    bus.memread = 1'b0;
    bus.m_ready = 1'b1;
    cyc();
    cyc();

    // Simultaneous enqueue/dequeue at count 2 across pointer wraps
    bus.m_ready  = 1'b0;
    bus.memwrite = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.dataadr   = $urandom;
      bus.writedata = $urandom;
      cyc();
    end
    bus.m_ready = 1'b1;
    for (int k = 0; k < 3 * DEPTH; k++) begin
      bus.dataadr   = $urandom;
      bus.writedata = $urandom;
      cyc();
      check("steady_count", 64'(bus.count), 64'd2);
    end
    bus.memwrite = 1'b0;
    cyc();
    cyc();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      bus.memwrite  = 1'($urandom_range(0, 1));
      bus.memread   = 1'($urandom_range(0, 1));
      bus.m_ready   = ($urandom_range(0, 2) == 0);
      bus.dataadr   = 32'($urandom_range(0, 31));
      bus.writedata = $urandom;
      cyc();
    end
    bus.memwrite = 1'b0;
    bus.memread  = 1'b0;
    bus.m_ready  = 1'b1;
    for (int k = 0; k <= DEPTH; k++) cyc();
    check("rand_drained", 64'(bus.empty), 64'd1);

    // Reset mid-drain
    bus.m_ready  = 1'b0;
    bus.memwrite = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.dataadr   = 32'(100 + 4 * k);
      bus.writedata = 32'(k + 1);
      cyc();
    end
    bus.memwrite = 1'b0;
    check("pre_rst_count", 64'(bus.count), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("async_rst_count",   64'(bus.count), 64'd0);
    reset       = 1'b0;
    bus.memread = 1'b1;
    bus.dataadr = 32'd104;
    bus.m_ready = 1'b1;
    #1;
    check("post_rst_fwd", 64'(bus.fwd_hit), 64'd0);
    cyc();
    check("post_rst_no_drain", 64'(bus.m_valid), 64'd0);
    bus.memread = 1'b0;

    // Same-cycle store and load on an empty buffer
    bus.m_ready   = 1'b0;
    bus.memwrite  = 1'b1;
    bus.memread   = 1'b1;
    bus.dataadr   = 32'd60;
    bus.writedata = 32'h55;
    #1;
    check("same_cycle_fwd", 64'(bus.fwd_hit), 64'd0);
    cyc();
    bus.memwrite = 1'b0;
    #1;
    check("next_cycle_fwd",  64'(bus.fwd_hit), 64'd1);
    check("next_cycle_data", 64'(bus.fwd_data), 64'h55);
    bus.m_ready = 1'b1;
    cyc();
    bus.memread = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
